mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between the CPU load/store port and the UART debug controller.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_wait_ctr.sv | 26 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_HALTED = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// rtl/mem_arb_wait_ctr.sv - saturating starvation counter for pending debug requests
module mem_arb_wait_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != CW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign at_max = (wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/debug arbiter for the single-port unified memory
// Optional MEM_ARB_PERF_EN adds the conflict_cnt performance counter port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cpu_halt,
  output logic                     halted_ack,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic [DATA_W/BYTE_W-1:0] cpu_be,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [DATA_W-1:0]        cpu_rdata,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDR_W-1:0]        dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic                     dbg_gnt,
  output logic                     dbg_rvalid,
  output logic [DATA_W-1:0]        dbg_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W/BYTE_W-1:0] mem_be,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]              conflict_cnt,
`endif
  input  logic [DATA_W-1:0]        mem_rdata
);

  arb_state_t state;
  owner_t     own1, own2;
  logic       rd1;
  logic       at_max;

  // A halt request seen in RUN blocks every grant that cycle, so no new op races the drain.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!RST) begin
      case (state)
        ARB_RUN: begin
          if (!cpu_halt) begin
            dbg_gnt = dbg_req && (!cpu_req || at_max);
            cpu_gnt = cpu_req && !dbg_gnt;
          end
        end
        ARB_HALTED: dbg_gnt = dbg_req && cpu_halt;
        default: ;
      endcase
    end
  end

  mem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
    .CLK    (CLK),
    .RST    (RST),
    .inc    (dbg_req && !dbg_gnt && (state == ARB_RUN)),
    .clr    (dbg_gnt || !dbg_req),
    .at_max (at_max)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ARB_RUN;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      own1      <= OWN_NONE;
      rd1       <= 1'b0;
      own2      <= OWN_NONE;
    end else begin
      case (state)
        ARB_RUN:    if (cpu_halt) state <= ARB_DRAIN;
        // Stage 2 retires this cycle, so only a stage-1 CPU op can still be in flight next cycle.
        ARB_DRAIN: begin
          if (!cpu_halt)            state <= ARB_RUN;
          else if (own1 != OWN_CPU) state <= ARB_HALTED;
        end
        ARB_HALTED: if (!cpu_halt) state <= ARB_RUN;
        default:    state <= ARB_RUN;
      endcase

      mem_en <= cpu_gnt || dbg_gnt;
      mem_we <= 1'b0;
      own1   <= OWN_NONE;
      rd1    <= 1'b0;
      if (cpu_gnt) begin
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_be    <= cpu_be;
        own1      <= OWN_CPU;
        rd1       <= !cpu_we;
      end else if (dbg_gnt) begin
        mem_we    <= dbg_we;
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
        mem_be    <= '1;
        own1      <= OWN_DBG;
        rd1       <= !dbg_we;
      end
      own2 <= rd1 ? own1 : OWN_NONE;
    end
  end

  assign halted_ack = (state == ARB_HALTED);
  assign cpu_rvalid = (own2 == OWN_CPU);
  assign dbg_rvalid = (own2 == OWN_DBG);
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST)                     conflict_cnt <= '0;
    else if (cpu_req && dbg_req) conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        CLK, RST;
  logic        cpu_halt, halted_ack;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [0:255];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
    .CLK(CLK), .RST(RST), .cpu_halt(cpu_halt), .halted_ack(halted_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be),
`ifdef MEM_ARB_PERF_EN
    .conflict_cnt(conflict_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory macro model: synchronous read, byte-lane write.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic test_reset();
    RST = 1; cpu_halt = 0; idle_inputs();
    repeat (3) cyc();
    RST = 0;
    mid();
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    vectors++; if (mem_be !== 4'h0) begin miscompares++; $display("FAIL reset_mem_be got %h want 0", mem_be); end
    vectors++; if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_rvalid got %b want 0", cpu_rvalid); end
    vectors++; if (dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_dbg_rvalid got %b want 0", dbg_rvalid); end
    vectors++; if (halted_ack !== 1'b0) begin miscompares++; $display("FAIL reset_halted_ack got %b want 0", halted_ack); end
  endtask

  task automatic test_cpu_read();
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    mid();
    vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL rd_cpu_gnt got %b want 1", cpu_gnt); end
    vectors++; if (dbg_gnt !== 1'b0) begin miscompares++; $display("FAIL rd_dbg_gnt got %b want 0", dbg_gnt); end
    cyc(); idle_inputs(); mid();
    vectors++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      miscompares++; $display("FAIL rd_mem_cmd got en=%b we=%b addr=%h want 1 0 00000100", mem_en, mem_we, mem_addr); end
    vectors++; if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_early_rvalid got %b want 0", cpu_rvalid); end
    cyc(); mid();
    vectors++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin
      miscompares++; $display("FAIL rd_cpu_rvalid got %b/%h want 1/12345678", cpu_rvalid, cpu_rdata); end
    vectors++; if (dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_dbg_rvalid got %b want 0", dbg_rvalid); end
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rd_mem_en_idle got %b want 0", mem_en); end
    cyc(); mid();
    vectors++; if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_rvalid_pulse got %b want 0", cpu_rvalid); end
  endtask

  task automatic test_cpu_write();
    cyc();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h104; cpu_wdata = 32'hA5A5_1234; cpu_be = 4'hC;
    mid();
    vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_cpu_gnt got %b want 1", cpu_gnt); end
    cyc(); idle_inputs(); mid();
    vectors++; if (mem_we !== 1'b1 || mem_be !== 4'hC || mem_wdata !== 32'hA5A5_1234) begin
      miscompares++; $display("FAIL wr_mem_cmd got we=%b be=%h d=%h want 1 c a5a51234", mem_we, mem_be, mem_wdata); end
    cyc(); mid();
    vectors++; if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL wr_no_rvalid got %b want 0", cpu_rvalid); end
    cyc(); mid();
    vectors++; if (mem[65] !== 32'hA5A5_0000) begin miscompares++; $display("FAIL wr_mem_contents got %h want a5a50000", mem[65]); end
  endtask

  task automatic test_starvation();
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    for (int k = 0; k < 8; k++) begin
      mid();
      vectors++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
        miscompares++; $display("FAIL starve_k%0d got cpu=%b dbg=%b want 1 0", k, cpu_gnt, dbg_gnt); end
      cyc();
    end
    mid();
    vectors++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1) begin
      miscompares++; $display("FAIL starve_max got cpu=%b dbg=%b want 0 1", cpu_gnt, dbg_gnt); end
    cyc(); dbg_req = 0; mid();
    vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL starve_resume got %b want 1", cpu_gnt); end
    cyc(); cpu_req = 0; mid();
    vectors++; if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== 32'h0BAD_F00D) begin
      miscompares++; $display("FAIL starve_dbg_rvalid got d=%b c=%b data=%h want 1 0 0badf00d", dbg_rvalid, cpu_rvalid, dbg_rdata); end
    cyc(); mid();
    vectors++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL starve_cpu_rvalid got c=%b d=%b want 1 0", cpu_rvalid, dbg_rvalid); end
    cyc();
  endtask

  task automatic test_halt_drain();
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    mid();
    vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL drain_gnt got %b want 1", cpu_gnt); end
    cyc(); cpu_halt = 1; mid();
    vectors++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      miscompares++; $display("FAIL drain_halt_cycle got cpu=%b dbg=%b want 0 0", cpu_gnt, dbg_gnt); end
    cyc(); mid();
    vectors++; if (cpu_rvalid !== 1'b1 || cpu_gnt !== 1'b0 || halted_ack !== 1'b0) begin
      miscompares++; $display("FAIL drain_rvalid got rv=%b gnt=%b ack=%b want 1 0 0", cpu_rvalid, cpu_gnt, halted_ack); end
    cyc(); mid();
    vectors++; if (halted_ack !== 1'b1 || cpu_gnt !== 1'b0) begin
      miscompares++; $display("FAIL drain_halted got ack=%b gnt=%b want 1 0", halted_ack, cpu_gnt); end
  endtask

  task automatic test_halted_access();
    cyc();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
    mid();
    vectors++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      miscompares++; $display("FAIL halted_wr_gnt got dbg=%b cpu=%b want 1 0", dbg_gnt, cpu_gnt); end
    cyc(); dbg_we = 0; mid();
    vectors++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      miscompares++; $display("FAIL halted_rd_gnt got dbg=%b cpu=%b want 1 0", dbg_gnt, cpu_gnt); end
    vectors++; if (mem_we !== 1'b1 || mem_be !== 4'hF || mem_wdata !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL halted_wr_cmd got we=%b be=%h d=%h want 1 f deadbeef", mem_we, mem_be, mem_wdata); end
    cyc(); dbg_req = 0; mid();
    vectors++; if (dbg_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin
      miscompares++; $display("FAIL halted_wr_norv got rv=%b cpu=%b want 0 0", dbg_rvalid, cpu_gnt); end
    cyc(); mid();
    vectors++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEAD_BEEF || cpu_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL halted_rd_data got rv=%b d=%h crv=%b want 1 deadbeef 0", dbg_rvalid, dbg_rdata, cpu_rvalid); end
    cyc(); cpu_halt = 0; mid();
    vectors++; if (cpu_gnt !== 1'b0) begin miscompares++; $display("FAIL release_same_cycle got %b want 0", cpu_gnt); end
    cyc(); mid();
    vectors++; if (cpu_gnt !== 1'b1 || halted_ack !== 1'b0) begin
      miscompares++; $display("FAIL release_resume got gnt=%b ack=%b want 1 0", cpu_gnt, halted_ack); end
    cyc(); idle_inputs(); cyc(); cyc();
  endtask

  task automatic test_reset_mid_read();
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    mid();
    vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL rst_gnt got %b want 1", cpu_gnt); end
    cyc(); idle_inputs(); RST = 1; mid();
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL rst_pre_mem_en got %b want 1", mem_en); end
    cyc(); RST = 0; mid();
    vectors++; if (cpu_rvalid !== 1'b0 || mem_en !== 1'b0 || halted_ack !== 1'b0) begin
      miscompares++; $display("FAIL rst_drop got rv=%b en=%b ack=%b want 0 0 0", cpu_rvalid, mem_en, halted_ack); end
    cyc(); cpu_req = 1; dbg_req = 1; mid();
    vectors++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      miscompares++; $display("FAIL rst_run_state got cpu=%b dbg=%b want 1 0", cpu_gnt, dbg_gnt); end
    cyc(); idle_inputs(); cyc(); cyc();
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    RST = 1; cyc(); RST = 0;
    cpu_req = 1; dbg_req = 1; cpu_addr = 32'h0; dbg_addr = 32'h0;
    repeat (5) cyc();
    idle_inputs();
    mid();
    vectors++; if (conflict_cnt !== 32'd5) begin miscompares++; $display("FAIL perf_conflict got %0d want 5", conflict_cnt); end
    cyc(); cyc();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h1234_5678;
    mem[65] = 32'hFFFF_0000;
    mem[4]  = 32'h0BAD_F00D;
    mem_rdata = 32'h0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_starvation();
    test_halt_drain();
    test_halted_access();
    test_reset_mid_read();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
